pool2d_window_scheduler: RTL and testbench
==========================================

POOL2D_WINDOW_SCHEDULER -- requirements
Module: pool2d_window_scheduler

Interface
REQ-001 SHALL have parameter DATA_IN_0_PRECISION_0, default 8: element width, signed two's complement; output width is identical.
REQ-002 SHALL have parameter DATA_IN_0_WIDTH, default 8: input feature-map columns.
REQ-003 SHALL have parameter DATA_IN_0_HEIGHT, default 8: input feature-map rows.
REQ-004 SHALL have parameters DATA_OUT_0_WIDTH and DATA_OUT_0_HEIGHT, default 2 each: output map columns and rows.
REQ-005 SHALL have parameters KERNEL_WIDTH and KERNEL_HEIGHT, default 2 each, and STRIDE, default 2: pooling window size and step.
REQ-006 SHALL derive ADDR_WIDTH = max(1, clog2(DATA_IN_0_WIDTH*DATA_IN_0_HEIGHT)) and ACC_WIDTH = DATA_IN_0_PRECISION_0 + clog2(KERNEL_WIDTH*KERNEL_HEIGHT) as localparams.
REQ-007 SHALL have ports, one per line, clock and reset first:
 clk  in  1  sole clock, rising edge
 rst  in  1  asynchronous, active-low reset
 start  in  1  one-cycle request to pool one frame
 busy  out  1  high from accepted start until frame complete
 done  out  1  one-cycle pulse after the last output handshake
 mem_rd_en  out  1  read strobe to frame buffer
 mem_rd_addr  out  ADDR_WIDTH  row-major element address, row*DATA_IN_0_WIDTH+col
 mem_rd_data  in  DATA_IN_0_PRECISION_0  read data, valid exactly 1 cycle after mem_rd_en
 data_out_0  out  DATA_IN_0_PRECISION_0  averaged element
 data_out_0_valid  out  1  output valid
 data_out_0_ready  in  1  downstream ready
 data_out_0_last  out  1  high with the final output of a frame

Function
REQ-008 SHALL implement FSM states IDLE, FETCH, DRAIN, EMIT.
REQ-009 IDLE: start=1 SHALL clear the accumulator, zero counters oy, ox, m, n, and enter FETCH; start in any other state SHALL be ignored.
REQ-010 FETCH: each cycle SHALL assert mem_rd_en with address (oy*STRIDE+m)*DATA_IN_0_WIDTH + (ox*STRIDE+n), with n innermost then m; after issuing (m,n)=(KERNEL_HEIGHT-1,KERNEL_WIDTH-1) SHALL enter DRAIN.
REQ-011 The accumulator SHALL add sign-extended mem_rd_data on every cycle after a cycle with mem_rd_en=1, including the DRAIN cycle; DRAIN SHALL last exactly one cycle, then EMIT.
REQ-012 On entering EMIT, data_out_0 SHALL equal sum/(KERNEL_WIDTH*KERNEL_HEIGHT), truncated toward zero, as a DATA_IN_0_PRECISION_0-bit value (no overflow is possible).
REQ-013 EMIT: data_out_0_valid=1; data_out_0 and data_out_0_last SHALL remain stable until data_out_0_valid && data_out_0_ready.
REQ-014 On handshake SHALL advance ox, wrapping to 0 and incrementing oy at DATA_OUT_0_WIDTH-1, clear the accumulator and return to FETCH; after output (DATA_OUT_0_HEIGHT-1, DATA_OUT_0_WIDTH-1) SHALL instead go to IDLE, pulse done for one cycle, and deassert busy.
REQ-015 data_out_0_last SHALL be 1 only in EMIT for the final output position.
REQ-016 Outputs SHALL appear in raster order; per-output latency without backpressure SHALL be KERNEL_WIDTH*KERNEL_HEIGHT+1 cycles from first read to valid.
REQ-017 mem_rd_en SHALL be 0 in IDLE, DRAIN, and EMIT; no read SHALL be issued while an output is pending.
REQ-018 Out-of-range windows are a parameterisation error: elaboration SHALL assert (DATA_OUT_0_HEIGHT-1)*STRIDE+KERNEL_HEIGHT <= DATA_IN_0_HEIGHT, and likewise for width.
REQ-019 start asserted in the same cycle as done SHALL be ignored; a new start is accepted from the following cycle.

Reset
REQ-020 rst=0 SHALL asynchronously force IDLE, clear all counters and the accumulator, and drive busy, done, mem_rd_en, data_out_0_valid, and data_out_0_last to 0, with data_out_0 and mem_rd_addr set to 0.
REQ-021 Reset asserted mid-frame SHALL abandon the frame with no done pulse; the first start after release SHALL begin at output (0,0).

Verification
REQ-022 Defaults, mem[i]=i, ready=1, start pulse: reads 0,1,8,9 then 2,3,10,11, 16,17,24,25, 18,19,26,27; outputs 4, 6, 20, 22, with last set on 22 and done one cycle after.
REQ-023 Window {-1,-1,-1,0} (0xFF,0xFF,0xFF,0x00): output 0x00, truncated toward zero, not -1.
REQ-024 All elements 0x80 -> every output 0x80; all 0x7F -> every output 0x7F; no wrap.
REQ-025 Hold ready=0 for 5 cycles in EMIT: valid stays 1, data and last stay constant, and mem_rd_en stays 0; the frame completes normally after ready rises.
REQ-026 Assert rst=0 during FETCH of output (1,0): all outputs go to 0 immediately with no done; a restart reproduces the sequence 4, 6, 20, 22.
REQ-027 Pulse start while busy and coincident with done: no second frame starts and the read count stays at 16.

Source files
------------

// File: rtl/pool2d_window_scheduler.sv
// Average-pooling window scheduler: walks each KERNEL_HEIGHT x KERNEL_WIDTH window of a
// frame buffer, accumulates it and emits one truncated average per output position.
module pool2d_window_scheduler #(
  parameter int DATA_IN_0_PRECISION_0 = 8,
  parameter int DATA_IN_0_WIDTH       = 8,
  parameter int DATA_IN_0_HEIGHT      = 8,
  parameter int DATA_OUT_0_WIDTH      = 2,
  parameter int DATA_OUT_0_HEIGHT     = 2,
  parameter int KERNEL_WIDTH          = 2,
  parameter int KERNEL_HEIGHT         = 2,
  parameter int STRIDE                = 2,
  localparam int ADDR_WIDTH = (DATA_IN_0_WIDTH * DATA_IN_0_HEIGHT > 1) ?
                              $clog2(DATA_IN_0_WIDTH * DATA_IN_0_HEIGHT) : 1,
  localparam int ACC_WIDTH  = DATA_IN_0_PRECISION_0 + $clog2(KERNEL_WIDTH * KERNEL_HEIGHT)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                   mem_rd_addr,
  input  logic signed [DATA_IN_0_PRECISION_0-1:0] mem_rd_data,
  output logic signed [DATA_IN_0_PRECISION_0-1:0] data_out_0,
  output logic                                    data_out_0_valid,
  input  logic                                    data_out_0_ready,
  output logic                                    data_out_0_last
);

  localparam int CW = $clog2(DATA_IN_0_WIDTH * DATA_IN_0_HEIGHT + 1);
  localparam logic signed [ACC_WIDTH:0] KDIV = (ACC_WIDTH + 1)'(KERNEL_WIDTH * KERNEL_HEIGHT);

  if ((DATA_OUT_0_HEIGHT - 1) * STRIDE + KERNEL_HEIGHT > DATA_IN_0_HEIGHT) begin : g_bad_height
    $error("pool2d_window_scheduler: output rows exceed input height");
  end
  if ((DATA_OUT_0_WIDTH - 1) * STRIDE + KERNEL_WIDTH > DATA_IN_0_WIDTH) begin : g_bad_width
    $error("pool2d_window_scheduler: output columns exceed input width");
  end

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, EMIT} state_t;

  state_t                       state, state_next;
  logic [CW-1:0]                oy, ox, m, n;
  logic signed [ACC_WIDTH-1:0]  acc, acc_sum;
  logic                         vld_p1;
  logic                         final_pos, win_end, start_ok;

  // Signed division truncates toward zero, so a small negative sum averages to 0.
  function automatic logic signed [DATA_IN_0_PRECISION_0-1:0] avg(
    input logic signed [ACC_WIDTH-1:0] s);
    logic signed [ACC_WIDTH:0] q;
    q = (ACC_WIDTH + 1)'(s) / KDIV;
    return DATA_IN_0_PRECISION_0'(q);
  endfunction

  assign acc_sum   = acc + ACC_WIDTH'(mem_rd_data);
  assign final_pos = (oy == CW'(DATA_OUT_0_HEIGHT - 1)) && (ox == CW'(DATA_OUT_0_WIDTH - 1));
  assign win_end   = (m == CW'(KERNEL_HEIGHT - 1)) && (n == CW'(KERNEL_WIDTH - 1));
  // A start coinciding with the done pulse is dropped.
  assign start_ok  = start && !done;

  always_comb begin
    state_next       = state;
    busy             = (state != IDLE);
    mem_rd_en        = 1'b0;
    mem_rd_addr      = '0;
    data_out_0_valid = 1'b0;
    data_out_0_last  = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_next = FETCH;
      FETCH: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = ADDR_WIDTH'((int'(oy) * STRIDE + int'(m)) * DATA_IN_0_WIDTH
                                  + int'(ox) * STRIDE + int'(n));
        if (win_end) state_next = DRAIN;
      end
      DRAIN: state_next = EMIT;
      EMIT: begin
        data_out_0_valid = 1'b1;
        data_out_0_last  = final_pos;
        if (data_out_0_ready) state_next = final_pos ? IDLE : FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      oy         <= '0;
      ox         <= '0;
      m          <= '0;
      n          <= '0;
      acc        <= '0;
      vld_p1     <= 1'b0;
      done       <= 1'b0;
      data_out_0 <= '0;
    end else begin
      state  <= state_next;
      done   <= 1'b0;
      // p1: read data returns one cycle after the strobe
      vld_p1 <= mem_rd_en;
      if (vld_p1) acc <= acc_sum;
      case (state)
        IDLE: if (start_ok) begin
          oy  <= '0;
          ox  <= '0;
          m   <= '0;
          n   <= '0;
          acc <= '0;
        end
        FETCH: begin
          if (n == CW'(KERNEL_WIDTH - 1)) begin
            n <= '0;
            m <= (m == CW'(KERNEL_HEIGHT - 1)) ? '0 : m + CW'(1);
          end else begin
            n <= n + CW'(1);
          end
        end
        DRAIN: data_out_0 <= avg(acc_sum);
        EMIT: if (data_out_0_ready) begin
          acc <= '0;
          if (final_pos) begin
            oy   <= '0;
            ox   <= '0;
            done <= 1'b1;
          end else if (ox == CW'(DATA_OUT_0_WIDTH - 1)) begin
            ox <= '0;
            oy <= oy + CW'(1);
          end else begin
            ox <= ox + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pool2d_window_scheduler.sv
// Randomised bench for pool2d_window_scheduler: a frame-buffer model plus a window-average
// reference computed directly from the memory contents.
module tb_pool2d_window_scheduler;

  localparam int P  = 8;
  localparam int IW = 8;
  localparam int IH = 8;
  localparam int OW = 2;
  localparam int OH = 2;
  localparam int KW = 2;
  localparam int KH = 2;
  localparam int S  = 2;
  localparam int NOUT = OW * OH;
  localparam int NRD  = NOUT * KW * KH;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                busy, done, mem_rd_en;
  logic [5:0]          mem_rd_addr;
  logic signed [P-1:0] mem_rd_data;
  logic signed [P-1:0] data_out_0;
  logic                data_out_0_valid, data_out_0_ready, data_out_0_last;

  pool2d_window_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .data_out_0(data_out_0), .data_out_0_valid(data_out_0_valid),
    .data_out_0_ready(data_out_0_ready), .data_out_0_last(data_out_0_last)
  );

  always #5 clk = ~clk;

  logic signed [P-1:0] mem [IW*IH];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rd_q[$];
  logic [P-1:0] out_q[$];
  bit   last_q[$];
  int   done_cnt, done_cyc, hs_last_cyc, first_rd_cyc, first_vld_cyc;
  bit   seen_rd, seen_vld;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  always @(negedge clk) begin
    if (rst) begin
      if (mem_rd_en) begin
        if (!seen_rd) begin seen_rd = 1; first_rd_cyc = cyc; end
        rd_q.push_back(int'(mem_rd_addr));
      end
      if (data_out_0_valid && !seen_vld) begin seen_vld = 1; first_vld_cyc = cyc; end
      if (data_out_0_valid && data_out_0_ready) begin
        out_q.push_back(data_out_0);
        last_q.push_back(data_out_0_last);
        if (data_out_0_last) hs_last_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clear_mon();
    rd_q.delete(); out_q.delete(); last_q.delete();
    done_cnt = 0; done_cyc = -1; hs_last_cyc = -100;
    seen_rd = 0; seen_vld = 0; first_rd_cyc = 0; first_vld_cyc = 0;
  endtask

  // Reference: each output is the window sum over the frame divided by the window size.
  task automatic compare_frame();
    int exp_rd[$];
    logic [P-1:0] exp_out[$];
    for (int oy = 0; oy < OH; oy++)
      for (int ox = 0; ox < OW; ox++) begin
        int sum = 0;
        for (int m = 0; m < KH; m++)
          for (int n = 0; n < KW; n++) begin
            int a = (oy * S + m) * IW + ox * S + n;
            exp_rd.push_back(a);
            sum += int'(mem[a]);
          end
        exp_out.push_back(P'(sum / (KW * KH)));
      end
    check("read_count", rd_q.size(), NRD);
    for (int i = 0; i < rd_q.size() && i < NRD; i++) check("read_addr", rd_q[i], exp_rd[i]);
    check("out_count", out_q.size(), NOUT);
    for (int i = 0; i < out_q.size() && i < NOUT; i++) begin
      check("out_data", 32'(out_q[i]), 32'(exp_out[i]));
      check("out_last", 32'(last_q[i]), 32'(i == NOUT - 1));
    end
    check("done_count", done_cnt, 1);
    check("done_after_last", done_cyc, hs_last_cyc + 1);
    check("first_latency", first_vld_cyc - first_rd_cyc, KW * KH + 1);
    check("busy_after", 32'(busy), 0);
  endtask

  // rmode: 0 ready high, 1 random ready, 2 ready held low for 5 cycles on first output
  task automatic run_frame(input int rmode, input bit dbl);
    bit got = 0;
    int held = 0;
    logic [P-1:0] hd;
    bit hl;
    clear_mon();
    data_out_0_ready = (rmode == 2) ? 1'b0 : 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin got = 1; break; end
      if (rmode == 1) data_out_0_ready = 1'($urandom);
      else if (rmode == 2) begin
        if (held < 5) begin
          data_out_0_ready = 1'b0;
          if (data_out_0_valid) begin
            if (held == 0) begin hd = data_out_0; hl = data_out_0_last; end
            else begin
              check("hold_valid", 32'(data_out_0_valid), 1);
              check("hold_data", 32'(data_out_0), 32'(hd));
              check("hold_last", 32'(data_out_0_last), 32'(hl));
              check("hold_no_read", 32'(mem_rd_en), 0);
            end
            held++;
          end
        end else data_out_0_ready = 1'b1;
      end
      if (dbl && i == 3) start = 1'b1;
    end
    check("frame_done_seen", 32'(got), 1);
    if (got && dbl) begin
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    data_out_0_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    compare_frame();
  endtask

  initial begin
    bit found = 0;
    rst = 1'b0; start = 1'b0; data_out_0_ready = 1'b1;
    for (int i = 0; i < IW * IH; i++) mem[i] = '0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    check("rst_addr", 32'(mem_rd_addr), 0);
    check("rst_valid", 32'(data_out_0_valid), 0);
    check("rst_last", 32'(data_out_0_last), 0);
    check("rst_data", 32'(data_out_0), 0);
    rst = 1'b1;

    for (int i = 0; i < IW * IH; i++) mem[i] = P'(i);
    run_frame(0, 0);
    if (out_q.size() == 4) begin
      check("ramp_out0", 32'(out_q[0]), 4);
      check("ramp_out1", 32'(out_q[1]), 6);
      check("ramp_out2", 32'(out_q[2]), 20);
      check("ramp_out3", 32'(out_q[3]), 22);
    end else check("ramp_out_count", out_q.size(), 4);

    for (int i = 0; i < IW * IH; i++) mem[i] = '0;
    mem[0] = 8'hFF; mem[1] = 8'hFF; mem[8] = 8'hFF; mem[9] = 8'h00;
    run_frame(0, 0);
    if (out_q.size() > 0) check("neg_trunc", 32'(out_q[0]), 0);
    else check("neg_trunc_count", out_q.size(), 4);

    for (int i = 0; i < IW * IH; i++) mem[i] = 8'h80;
    run_frame(1, 0);
    if (out_q.size() > 0) check("all_min", 32'(out_q[0]), 32'h80);
    for (int i = 0; i < IW * IH; i++) mem[i] = 8'h7F;
    run_frame(0, 0);
    if (out_q.size() > 0) check("all_max", 32'(out_q[0]), 32'h7F);

    for (int i = 0; i < IW * IH; i++) mem[i] = P'(i);
    run_frame(2, 0);

    for (int i = 0; i < IW * IH; i++) mem[i] = P'($urandom);
    run_frame(1, 1);
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < IW * IH; i++) mem[i] = P'($urandom);
      run_frame(int'($urandom_range(0, 1)), 0);
    end

    for (int i = 0; i < IW * IH; i++) mem[i] = P'(i);
    clear_mon();
    data_out_0_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (out_q.size() == 2 && mem_rd_en) begin found = 1; break; end
    end
    check("reach_fetch_1_0", 32'(found), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rd_en", 32'(mem_rd_en), 0);
    check("mid_rst_addr", 32'(mem_rd_addr), 0);
    check("mid_rst_valid", 32'(data_out_0_valid), 0);
    check("mid_rst_last", 32'(data_out_0_last), 0);
    check("mid_rst_data", 32'(data_out_0), 0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_done_count", done_cnt, 0);
    rst = 1'b1;
    run_frame(0, 0);
    if (out_q.size() == 4) begin
      check("restart_out0", 32'(out_q[0]), 4);
      check("restart_out3", 32'(out_q[3]), 22);
    end else check("restart_out_count", out_q.size(), 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
